// File: rtl/slot_pkg.sv
// slot_pkg: slot-bus register map, sequencer state type
// and the operand-pair bundle shared by slot_master_seq.
package slot_pkg;

  localparam logic [4:0] ADDR_RES = 5'b00000;
  localparam logic [4:0] ADDR_A   = 5'b00001;
  localparam logic [4:0] ADDR_B   = 5'b00010;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    WAIT,
    RD
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_pair_t;

endpackage

// File: rtl/slot_master_seq_if.sv
// slot_master_seq_if: operand push, result pop and slot-bus
// signals of the sequencer, with master/slave views.
interface slot_master_seq_if;

  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    input  op_valid, op_a, op_b,
    input  res_ready, rd_data,
    output op_ready, res_valid, res_data,
    output cs, read, write, addr, wr_data
  );

  modport slave (
    output op_valid, op_a, op_b,
    output res_ready, rd_data,
    input  op_ready, res_valid, res_data,
    input  cs, read, write, addr, wr_data
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered count, no bypass.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers and occupancy; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push)
                       - (AW+1)'(do_pop);
  end

  // Pointer and count state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/slot_master_seq.sv
// slot_master_seq: runs WR_A/WR_B/WAIT/RD slot-bus cycles per pair.
// SLOT_MASTER_PERF_EN adds a busy-cycle counter on busy_cycles.
module slot_master_seq
  import slot_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  slot_master_seq_if.master bus,
  output logic              busy,
  output logic [31:0]       txn_count,
  output logic [31:0]       busy_cycles
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [7:0] WAIT_INIT =
    (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  op_pair_t    op_din, op_head;
  logic        op_full, op_empty, op_pop;
  logic        res_full, res_empty, res_push;
  logic [CW-1:0] unused_op_count;
  logic [CW-1:0] unused_res_count;

  state_e      state_q, state_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] txn_q, txn_d;

  assign op_din       = '{a: bus.op_a, b: bus.op_b};
  assign bus.op_ready = !op_full && !reset;
  assign bus.res_valid = !res_empty && !reset;

  sync_fifo #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_op_fifo (
    .clk  (clk),
    .reset(reset),
    .push (bus.op_valid && bus.op_ready),
    .din  (op_din),
    .pop  (op_pop),
    .dout (op_head),
    .full (op_full),
    .empty(op_empty),
    .count(unused_op_count)
  );

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_res_fifo (
    .clk  (clk),
    .reset(reset),
    .push (res_push),
    .din  (bus.rd_data),
    .pop  (bus.res_ready && bus.res_valid),
    .dout (bus.res_data),
    .full (res_full),
    .empty(res_empty),
    .count(unused_res_count)
  );

  // Next state plus bus strobes for the state being entered,
  // so the registered strobes always match the registered state.
  always_comb begin
    state_d  = state_q;
    cs_d     = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    wait_d   = wait_q;
    txn_d    = txn_q;
    op_pop   = 1'b0;
    res_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!op_empty && !res_full) begin
          state_d = WR_A;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = ADDR_A;
          wdata_d = op_head.a;
        end
      end
      WR_A: begin
        state_d = WR_B;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = ADDR_B;
        wdata_d = op_head.b;
      end
      WR_B: begin
        op_pop = 1'b1;
        if (LATENCY == 0) begin
          state_d = RD;
          cs_d    = 1'b1;
          rd_d    = 1'b1;
          addr_d  = ADDR_RES;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      WAIT: begin
        if (wait_q == 8'd0) begin
          state_d = RD;
          cs_d    = 1'b1;
          rd_d    = 1'b1;
          addr_d  = ADDR_RES;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      RD: begin
        res_push = 1'b1;
        txn_d    = txn_q + 32'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      txn_q   <= txn_d;
    end
  end

  assign bus.cs      = cs_q;
  assign bus.read    = rd_q;
  assign bus.write   = wr_q;
  assign bus.addr    = addr_q;
  assign bus.wr_data = wdata_q;
  assign busy        = (state_q != IDLE);
  assign txn_count   = txn_q;

`ifdef SLOT_MASTER_PERF_EN
  logic [31:0] bcyc_q, bcyc_d;

  // Count every cycle spent outside IDLE.
  always_comb begin
    bcyc_d = bcyc_q + 32'(busy);
  end

  // Busy-cycle counter state.
  always_ff @(posedge clk) begin
    if (reset) bcyc_q <= '0;
    else       bcyc_q <= bcyc_d;
  end

  assign busy_cycles = bcyc_q;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_slot_master_seq.sv
// tb_slot_master_seq: slot responders with fixed latency plus a
// result scoreboard, for the LATENCY=4 and LATENCY=0 builds.
module tb_slot_master_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  slot_master_seq_if m();
  slot_master_seq_if z();

  logic        busy, busy0;
  logic [31:0] txn_count, txn0, bcyc, bcyc0;

  slot_master_seq #(.LATENCY(4), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(m),
    .busy(busy), .txn_count(txn_count), .busy_cycles(bcyc)
  );

  slot_master_seq #(.LATENCY(0), .DEPTH(8)) dut0 (
    .clk(clk), .reset(reset), .bus(z),
    .busy(busy0), .txn_count(txn0), .busy_cycles(bcyc0)
  );

`ifdef SLOT_MASTER_PERF_EN
  localparam logic [31:0] BCYC1 = 32'd7;
`else
  localparam logic [31:0] BCYC1 = 32'd0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  tag, got, exp);
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    return r2f($itor($urandom_range(1, 1000)));
  endfunction

  // Responder, latency 4: reads before the result is due see junk.
  logic [31:0] ra = '0, rres = '0;
  int rcnt = 0;
  always @(posedge clk) begin
    if (m.cs && m.write && m.addr == 5'd1) ra <= m.wr_data;
    if (m.cs && m.write && m.addr == 5'd2) begin
      rres <= fadd(ra, m.wr_data);
      rcnt <= 4;
    end else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
    end
  end
  assign m.rd_data = (rcnt == 0) ? rres : 32'hDEAD_BEEF;

  // Responder, latency 0.
  logic [31:0] za = '0, zres = '0;
  always @(posedge clk) begin
    if (z.cs && z.write && z.addr == 5'd1) za <= z.wr_data;
    if (z.cs && z.write && z.addr == 5'd2)
      zres <= fadd(za, z.wr_data);
  end
  assign z.rd_data = zres;

  // Scoreboard: every popped result against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && m.res_valid && m.res_ready) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        check("res_data", m.res_data, exp_q.pop_front());
    end
  end

  task automatic push_m(input logic [31:0] a,
                        input logic [31:0] b);
    bit ok = 1'b0;
    m.op_valid = 1'b1;
    m.op_a = a;
    m.op_b = b;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = m.op_ready;
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(fadd(a, b));
      #1;
    end
    m.op_valid = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain(input string tag,
                       input logic [31:0] txn_exp);
    for (int i = 0; i < 800 && (exp_q.size() != 0 || busy); i++)
      @(negedge clk);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_txn"}, txn_count, txn_exp);
    check({tag, "_valid"}, 32'(m.res_valid), 32'd0);
  endtask

  function automatic logic [7:0] code_m();
    return {m.cs, m.read, m.write, m.addr};
  endfunction

  function automatic logic [7:0] code_z();
    return {z.cs, z.read, z.write, z.addr};
  endfunction

  logic [7:0] seq4 [9] = '{8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00,
                           8'h00, 8'h00, 8'hC0, 8'h00};
  logic [7:0] seq0 [5] = '{8'h00, 8'hA1, 8'hA2, 8'hC0, 8'h00};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, wd;
    m.op_valid = 0; m.op_a = 0; m.op_b = 0; m.res_ready = 0;
    z.op_valid = 0; z.op_a = 0; z.op_b = 0; z.res_ready = 0;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus", 32'(code_m()), 32'd0);
    check("rst_wdata", m.wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txn", txn_count, 32'd0);
    check("rst_bcyc", bcyc, 32'd0);
    check("rst_opready", 32'(m.op_ready), 32'd0);
    check("rst_resvalid", 32'(m.res_valid), 32'd0);
    check("rst_z_bus", 32'(code_z()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("opready_after_rst", 32'(m.op_ready), 32'd1);
    check("z_opready_after_rst", 32'(z.op_ready), 32'd1);

    // Reset while the transaction sits in WAIT.
    @(posedge clk); #1;
    push_m(r2f(3.0), r2f(4.0));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_quiet", 32'(code_m()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_bus", 32'(code_m()), 32'd0);
    check("abort_wdata", m.wr_data, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (12) @(negedge clk);
    check("abort_resvalid", 32'(m.res_valid), 32'd0);
    check("abort_txn", txn_count, 32'd0);
    check("abort_bcyc", bcyc, 32'd0);

    // Single transaction: 1.0 + 2.0, cycle-by-cycle bus trace.
    @(posedge clk); #1;
    a = 32'h3F80_0000;
    b = 32'h4000_0000;
    push_m(a, b);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      wd = (j == 1) ? a : (j == 2) ? b : 32'd0;
      check($sformatf("seq4_bus_%0d", j),
            32'(code_m()), 32'(seq4[j]));
      check($sformatf("seq4_wdata_%0d", j), m.wr_data, wd);
      check($sformatf("seq4_valid_%0d", j),
            32'(m.res_valid), 32'(j == 8));
    end
    check("single_res", m.res_data, 32'h4040_0000);
    check("single_txn", txn_count, 32'd1);
    check("single_busy", 32'(busy), 32'd0);
    check("single_bcyc", bcyc, BCYC1);
    @(posedge clk); #1;
    m.res_ready = 1'b1;
    @(posedge clk); #1;
    m.res_ready = 1'b0;
    check("single_popped", 32'(exp_q.size()), 32'd0);

    // Nine pairs with no result consumer.
    for (int i = 0; i < 9; i++) push_m(rnd_f(), rnd_f());
    @(negedge clk);
    check("op_full", 32'(m.op_ready), 32'd0);
    repeat (120) @(negedge clk);
    check("resfull_idle", 32'(busy), 32'd0);
    check("resfull_txn", txn_count, 32'd9);
    check("resfull_opready", 32'(m.op_ready), 32'd1);
    check("resfull_valid", 32'(m.res_valid), 32'd1);
    check("resfull_head", m.res_data, exp_q[0]);
    repeat (20) @(negedge clk);
    check("resfull_still_idle", 32'(busy), 32'd0);
    check("resfull_still_txn", txn_count, 32'd9);
    check("res_hold", m.res_data, exp_q[0]);
    @(posedge clk); #1;
    m.res_ready = 1'b1;
    drain("drain9", 32'd10);

    // Twenty pairs with the consumer always ready.
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) push_m(rnd_f(), rnd_f());
    drain("stream20", 32'd30);

    // Twelve pairs with a stalling consumer.
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      m.res_ready = 1'($urandom_range(0, 1));
      push_m(rnd_f(), rnd_f());
    end
    @(posedge clk); #1;
    m.res_ready = 1'b1;
    drain("rand12", 32'd42);

    // LATENCY=0 build: WR_B goes straight to RD.
    @(posedge clk); #1;
    z.op_valid = 1'b1;
    z.op_a = 32'h4000_0000;
    z.op_b = 32'h4040_0000;
    @(negedge clk);
    check("z_accept", 32'(z.op_ready), 32'd1);
    @(posedge clk); #1;
    z.op_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("seq0_bus_%0d", j),
            32'(code_z()), 32'(seq0[j]));
      check($sformatf("seq0_valid_%0d", j),
            32'(z.res_valid), 32'(j == 4));
    end
    check("z_res", z.res_data, 32'h40A0_0000);
    check("z_txn", txn0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/slot_master_seq.md
SLOT_MASTER_SEQ -- requirements
Module: slot_master_seq

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, which sets the responder result latency in clocks (legal 0..255).
REQ-002 The block SHALL have parameter DEPTH, default 8, which sets the entries per internal FIFO (power of two, 2..64).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have ports op_valid input 1, op_ready output 1, op_a input 32 and op_b input 32, forming the operand-pair push handshake.
REQ-006 The block SHALL have ports res_valid output 1, res_ready input 1 and res_data output 32, forming the result pop handshake.
REQ-007 The block SHALL have ports cs, read and write, each output 1, the slot-bus strobes.
REQ-008 The block SHALL have ports addr output 5 and wr_data output 32 for the slot-bus address and write data.
REQ-009 The block SHALL have port rd_data, input, 32, the slot-bus read data.
REQ-010 The block SHALL have ports busy output 1 (FSM not IDLE) and txn_count output 32 (completed transactions).

Function
REQ-011 The FSM SHALL have states IDLE, WR_A, WR_B, WAIT and RD; bus outputs SHALL be decoded from the registered state only.
REQ-012 In IDLE, the FSM SHALL go to WR_A when the operand FIFO is non-empty and the result FIFO count < DEPTH; otherwise it SHALL stay in IDLE.
REQ-013 WR_A SHALL drive cs=1, write=1, addr=ADDR_A (5'b00001) and wr_data=head op_a for one cycle, then go to WR_B.
REQ-014 WR_B SHALL drive cs=1, write=1, addr=ADDR_B (5'b00010) and wr_data=head op_b for one cycle, pop the operand FIFO, then go to WAIT (or RD if LATENCY=0).
REQ-015 WAIT SHALL hold all strobes at 0 for exactly LATENCY cycles, then go to RD.
REQ-016 RD SHALL drive cs=1, read=1, addr=ADDR_RES (5'b00000) for one cycle, push rd_data into the result FIFO at the closing edge, increment txn_count, then go to IDLE.
REQ-017 Outside WR_A, WR_B and RD, cs, read and write SHALL be 0, and addr and wr_data SHALL be 0.
REQ-018 With both FIFOs empty and idle, res_valid SHALL rise exactly LATENCY+5 cycles after the edge that accepts an operand pair; sustained throughput SHALL be one transaction per LATENCY+4 cycles.
REQ-019 op_ready SHALL equal not-full; a push offered while full SHALL be refused even if a pop occurs in the same cycle.
REQ-020 The result FIFO SHALL have no bypass: data pushed at an edge becomes visible at the next cycle, and simultaneous push and pop on a non-empty FIFO SHALL keep the count unchanged.
REQ-021 res_data SHALL hold stable while res_valid=1 and res_ready=0.
REQ-022 txn_count SHALL wrap modulo 2^32.

Reset
REQ-023 On reset, the block SHALL set the FSM to IDLE, empty both FIFOs, and drive busy, txn_count, cs, read, write, addr, wr_data, op_ready and res_valid to 0; op_ready SHALL be 1 from the first cycle after reset.
REQ-024 On reset mid-transaction, the block SHALL abandon the transaction with no result pushed, and the bus SHALL be quiet the cycle after the reset edge.

Configuration
REQ-025 With SLOT_MASTER_PERF_EN defined, the block SHALL add output busy_cycles (32), which counts cycles with busy=1, wraps, and clears on reset.
REQ-026 With SLOT_MASTER_PERF_EN undefined, busy_cycles SHALL still exist as a port, tied to 0, with no counter logic.

Structure
REQ-027 Package slot_pkg SHALL hold ADDR_A, ADDR_B, ADDR_RES and the FSM state enum typedef.
REQ-028 A sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) SHALL be instantiated twice: operand FIFO width 64, result FIFO width 32.

Verification
REQ-029 Reset-value check: reset held 3 cycles -> all outputs 0; op_ready=1 on the next cycle.
REQ-030 Single transaction: the bench SHALL pair the block with a responder model of fixed latency 4; push 0x3F800000/0x40000000 -> bus sequence WR_A, WR_B, 4 idle, RD; res_data=0x40400000 at cycle 9; txn_count=1.
REQ-031 Operand FIFO full: push 9 pairs with res_ready=0 (DEPTH=8) -> op_ready falls; after 8 results fill the result FIFO, the FSM stays in IDLE and busy=0.
REQ-032 Drain with simultaneous push/pop: hold res_ready=1 while pushing -> results appear in order; no loss or duplication over 20 pairs.
REQ-033 LATENCY=0 build: WR_B is followed directly by RD, and the result appears 5 cycles after accept.
REQ-034 Reset asserted during WAIT: no result is pushed, txn_count is unchanged at 0, and the bus is quiet on the next cycle; busy_cycles is checked with and without SLOT_MASTER_PERF_EN.
